// File: rtl/uart_pio_pkg.sv
// uart_pio_pkg: register addresses and edge-type encodings shared by the PIO input block
package uart_pio_pkg;
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/uart_pio_sync.sv
// uart_pio_sync: WIDTH-bit two-flop synchronizer with asynchronous active-low reset
module uart_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  assign q = sync2_q;
endmodule

// File: rtl/uart_pio_in.sv
// uart_pio_in: Avalon-MM PIO input port with edge capture, interrupt mask and level irq
module uart_pio_in
  import uart_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync2, sync_d_q, sync_d_d, mask_q, mask_d, cap_q, cap_d, edges;
  logic [31:0] readdata_q, readdata_d, rd_mux;
  logic wr, rd;
  logic unused_wd;
  assign unused_wd = ^writedata;
  uart_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (in_port),
    .q      (sync2)
  );
  // edge set is OR'd after the clear so a same-cycle edge wins over write-1-to-clear
  always_comb begin
    wr = chipselect & ~write_n;
    rd = chipselect & ~read_n;
    edges = EDGE_TYPE == EDGE_FALL ? ~sync2 & sync_d_q :
            EDGE_TYPE == EDGE_ANY  ? sync2 ^ sync_d_q  : sync2 & ~sync_d_q;
    sync_d_d = sync2;
    mask_d = wr && address == ADDR_IRQ_MASK ? writedata[WIDTH-1:0] : mask_q;
    cap_d = (wr && address == ADDR_EDGE_CAP ? cap_q & ~writedata[WIDTH-1:0] : cap_q) | edges;
    rd_mux = '0;
    rd_mux[WIDTH-1:0] = address == ADDR_DATA     ? sync2  :
                        address == ADDR_IRQ_MASK ? mask_q :
                        address == ADDR_EDGE_CAP ? cap_q  : '0;
    readdata_d = rd ? rd_mux : readdata_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_d_q   <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_d_q   <= sync_d_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  assign readdata = readdata_q;
  assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_uart_pio_in.sv
// tb_uart_pio_in: scoreboard bench driving rise, fall and any-edge instances on a shared bus
module tb_uart_pio_in;
  logic clk = 0, reset_n = 1;
  logic [1:0] address = 0;
  logic chipselect = 0, read_n = 1, write_n = 1;
  logic [31:0] writedata = 0;
  logic [7:0] in_port = 0;
  logic [31:0] rd0, rd1, rd2, e;
  logic irq0, irq1, irq2;
  int vectors = 0, errors = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  uart_pio_in #(.WIDTH(8), .EDGE_TYPE(0)) dut0 (.clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd0), .irq(irq0));
  uart_pio_in #(.WIDTH(8), .EDGE_TYPE(1)) dut1 (.clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd1), .irq(irq1));
  uart_pio_in #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (.clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd2), .irq(irq2));
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick(1);
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd(input logic [1:0] a);
    chipselect = 1; read_n = 0; address = a;
    tick(1);
    chipselect = 0; read_n = 1;
  endtask
  task automatic test_reset;
    #2 reset_n = 0;
    #2;
    exp_q.push_back(0);
    e = exp_q.pop_front(); vectors++;
    if ({rd0, rd1, rd2} !== {3{e}}) begin errors++; $display("FAIL reset_readdata: got %h %h %h want %h", rd0, rd1, rd2, e); end
    vectors++;
    if ({irq0, irq1, irq2} !== 3'b000) begin errors++; $display("FAIL reset_irq: got %b%b%b want 000", irq0, irq1, irq2); end
    tick(2);
    reset_n = 1;
  endtask
  task automatic test_data;
    in_port = 8'hA5;
    tick(5);
    exp_q.push_back(32'hA5);
    rd(0);
    e = exp_q.pop_front(); vectors++;
    if ({rd0, rd1, rd2} !== {3{e}}) begin errors++; $display("FAIL data_a5: got %h %h %h want %h", rd0, rd1, rd2, e); end
    exp_q.push_back(32'hA5); exp_q.push_back(32'h0); exp_q.push_back(32'hA5);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL cap_rise_after_reset: got %h want %h", rd0, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd1 !== e) begin errors++; $display("FAIL cap_fall_after_reset: got %h want %h", rd1, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd2 !== e) begin errors++; $display("FAIL cap_any_after_reset: got %h want %h", rd2, e); end
    wr(3, 32'hFF);
    exp_q.push_back(32'h0);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if ({rd0, rd1, rd2} !== {3{e}}) begin errors++; $display("FAIL cap_cleared: got %h %h %h want %h", rd0, rd1, rd2, e); end
  endtask
  task automatic test_rise_irq;
    wr(2, 32'h1);
    in_port = 8'h00;
    tick(4);
    wr(3, 32'hFF);
    in_port = 8'h01;
    tick(2);
    vectors++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq0); end
    tick(1);
    vectors++;
    if ({irq0, irq1} !== 2'b10) begin errors++; $display("FAIL irq_rise: got %b%b want 10", irq0, irq1); end
    exp_q.push_back(32'h1);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL cap_bit0: got %h want %h", rd0, e); end
    wr(3, 32'h1);
    vectors++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq0); end
  endtask
  task automatic test_fall;
    wr(2, 32'h0);
    wr(3, 32'hFF);
    in_port = 8'h09;
    tick(4);
    exp_q.push_back(32'h0); exp_q.push_back(32'h8);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd1 !== e) begin errors++; $display("FAIL fall_on_rise: got %h want %h", rd1, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL rise_bit3: got %h want %h", rd0, e); end
    in_port = 8'h01;
    tick(4);
    exp_q.push_back(32'h8);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd1 !== e) begin errors++; $display("FAIL fall_bit3: got %h want %h", rd1, e); end
    vectors++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL fall_irq_masked: got %b want 0", irq1); end
  endtask
  task automatic test_clear_race;
    wr(3, 32'hFF);
    in_port = 8'h05;
    tick(2);
    wr(3, 32'hFF);
    exp_q.push_back(32'h4); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL race_rise: got %h want %h", rd0, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd1 !== e) begin errors++; $display("FAIL race_fall: got %h want %h", rd1, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd2 !== e) begin errors++; $display("FAIL race_any: got %h want %h", rd2, e); end
  endtask
  task automatic test_regs;
    wr(0, 32'hFFFF_FFFF);
    wr(1, 32'hFFFF_FFFF);
    exp_q.push_back(32'h5);
    rd(0);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL data_after_write: got %h want %h", rd0, e); end
    exp_q.push_back(32'h0);
    rd(1);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL reserved: got %h want %h", rd0, e); end
    wr(2, 32'h1234_5655);
    exp_q.push_back(32'h55);
    rd(2);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL mask_rw: got %h want %h", rd0, e); end
    exp_q.push_back(32'h4);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL read_no_side_effect: got %h want %h", rd0, e); end
    chipselect = 1; read_n = 0; write_n = 0; address = 2; writedata = 32'hAA;
    exp_q.push_back(32'h55);
    tick(1);
    chipselect = 0; read_n = 1; write_n = 1;
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL rdwr_old: got %h want %h", rd0, e); end
    exp_q.push_back(32'hAA);
    rd(2);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL rdwr_new: got %h want %h", rd0, e); end
  endtask
  task automatic test_reset_mid_read;
    in_port = 8'hFA;
    wr(2, 32'hFF);
    tick(4);
    exp_q.push_back(32'hFF);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd2 !== e) begin errors++; $display("FAIL any_all_bits: got %h want %h", rd2, e); end
    vectors++;
    if (irq2 !== 1'b1) begin errors++; $display("FAIL irq_any: got %b want 1", irq2); end
    chipselect = 1; read_n = 0; address = 3;
    #2 reset_n = 0;
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if ({rd0, rd1, rd2} !== {3{e}}) begin errors++; $display("FAIL async_reset_readdata: got %h %h %h want %h", rd0, rd1, rd2, e); end
    vectors++;
    if ({irq0, irq1, irq2} !== 3'b000) begin errors++; $display("FAIL async_reset_irq: got %b%b%b want 000", irq0, irq1, irq2); end
    tick(1);
    chipselect = 0; read_n = 1; reset_n = 1;
    tick(4);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if ({rd0, rd1, rd2} !== {3{e}}) begin errors++; $display("FAIL read_discarded: got %h %h %h want %h", rd0, rd1, rd2, e); end
    exp_q.push_back(32'hFA); exp_q.push_back(32'h0); exp_q.push_back(32'hFA);
    rd(3);
    e = exp_q.pop_front(); vectors++;
    if (rd0 !== e) begin errors++; $display("FAIL post_reset_rise: got %h want %h", rd0, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd1 !== e) begin errors++; $display("FAIL post_reset_fall: got %h want %h", rd1, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd2 !== e) begin errors++; $display("FAIL post_reset_any: got %h want %h", rd2, e); end
  endtask
  initial begin
    test_reset;
    test_data;
    test_rise_irq;
    test_fall;
    test_clear_race;
    test_regs;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
